// File: rtl/fifo_write_ctl.sv
// fifo_write_ctl: write-side controller of a dual-clock FIFO.
// Holds the binary/Gray write pointer pair, brings the read-domain Gray
// pointer across with a two-flop synchronizer, and produces registered
// full, almost-full, fill level and sticky overflow status.
module fifo_write_ctl #(
    parameter int A_SIZE    = 4,
    parameter int AF_THRESH = 12
) (
    input  logic              wclk,
    input  logic              wrst,
    input  logic              wen,
    input  logic              ovf_clr,
    input  logic [A_SIZE:0]   rptr,
    output logic [A_SIZE-1:0] waddr,
    output logic [A_SIZE:0]   wptr,
    output logic              full,
    output logic              almost_full,
    output logic [A_SIZE:0]   wlevel,
    output logic              overflow
);

    // Threshold resized to the pointer width; legal values 1..2^A_SIZE fit.
    localparam logic [A_SIZE:0] AF_LIMIT = (A_SIZE + 1)'(AF_THRESH);

    // Registered state
    logic [A_SIZE:0] bin_reg;
    logic [A_SIZE:0] gray_reg;
    logic [A_SIZE:0] wq1_reg;
    logic [A_SIZE:0] wq2_reg;
    logic            full_reg;
    logic            almost_full_reg;
    logic [A_SIZE:0] wlevel_reg;
    logic            overflow_reg;

    // Next-state values
    logic            winc;
    logic [A_SIZE:0] bin_next;
    logic [A_SIZE:0] gray_next;
    logic [A_SIZE:0] rbin;
    logic [A_SIZE:0] full_pattern;
    logic [A_SIZE:0] level_next;
    logic            full_next;
    logic            almost_full_next;
    logic            overflow_next;

    // A write is only accepted while not full; a rejected write leaves the
    // pointers (and therefore the RAM address) untouched.
    assign winc      = wen & ~full_reg;
    assign bin_next  = bin_reg + {{A_SIZE{1'b0}}, winc};
    assign gray_next = (bin_next >> 1) ^ bin_next;

    // Gray-to-binary conversion of the synchronized read pointer:
    // each binary bit is the XOR of all Gray bits at or above it.
    generate
        for (genvar gi = 0; gi <= A_SIZE; gi++) begin : g_rbin
            assign rbin[gi] = ^wq2_reg[A_SIZE:gi];
        end
    endgenerate

    // Full when the next write pointer is exactly one lap ahead of the
    // read pointer: in Gray code that means the two MSBs are inverted and
    // the remaining bits match. This stays correct across both the address
    // wrap and the extra-lap-bit wrap.
    assign full_pattern = {~wq2_reg[A_SIZE:A_SIZE-1], wq2_reg[A_SIZE-2:0]};
    assign full_next    = (gray_next == full_pattern);

    // Fill level against a read pointer that is at least two cycles old,
    // so it can only over-report the occupancy, never under-report it.
    assign level_next       = bin_next - rbin;
    assign almost_full_next = (level_next >= AF_LIMIT);

    // Overflow is sticky; a new overflow on the same edge as a clear wins.
    always_comb begin
        overflow_next = overflow_reg;
        if (ovf_clr) begin
            overflow_next = 1'b0;
        end
        if (wen && full_reg) begin
            overflow_next = 1'b1;
        end
    end

    // Write pointer pair: binary for the RAM address, Gray for the read side.
    always_ff @(posedge wclk or posedge wrst) begin
        if (wrst) begin
            bin_reg  <= '0;
            gray_reg <= '0;
        end else begin
            bin_reg  <= bin_next;
            gray_reg <= gray_next;
        end
    end

    // Two-flop synchronizer for the read-domain Gray pointer.
    always_ff @(posedge wclk or posedge wrst) begin
        if (wrst) begin
            wq1_reg <= '0;
            wq2_reg <= '0;
        end else begin
            wq1_reg <= rptr;
            wq2_reg <= wq1_reg;
        end
    end

    // Registered status flags and fill level.
    always_ff @(posedge wclk or posedge wrst) begin
        if (wrst) begin
            full_reg        <= 1'b0;
            almost_full_reg <= 1'b0;
            wlevel_reg      <= '0;
            overflow_reg    <= 1'b0;
        end else begin
            full_reg        <= full_next;
            almost_full_reg <= almost_full_next;
            wlevel_reg      <= level_next;
            overflow_reg    <= overflow_next;
        end
    end

    assign waddr       = bin_reg[A_SIZE-1:0];
    assign wptr        = gray_reg;
    assign full        = full_reg;
    assign almost_full = almost_full_reg;
    assign wlevel      = wlevel_reg;
    assign overflow    = overflow_reg;

endmodule

// File: tb/tb_fifo_write_ctl.sv
// Testbench for fifo_write_ctl: behavioural occupancy model checked every
// cycle, plus directed literal checks for fill, overflow, drain, wrap and
// a second instance with a threshold of one.
module tb_fifo_write_ctl;

    localparam int A     = 4;
    localparam int DEPTH = 1 << A;
    localparam int LAP   = 2 * DEPTH;

    logic         wclk = 1'b0;
    logic         wrst = 1'b1;
    logic         wen = 1'b0;
    logic         ovf_clr = 1'b0;
    logic [A:0]   rptr = '0;
    logic [A-1:0] waddr;
    logic [A:0]   wptr;
    logic         full;
    logic         almost_full;
    logic [A:0]   wlevel;
    logic         overflow;

    logic         wen2 = 1'b0;
    logic [A:0]   rptr2 = '0;
    logic [A-1:0] waddr2;
    logic [A:0]   wptr2;
    logic         full2;
    logic         almost_full2;
    logic [A:0]   wlevel2;
    logic         overflow2;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    // Model state: total accepted writes, read pointer history, flags.
    int         m_wr;
    logic [A:0] m_s1, m_s2;
    bit         m_full, m_af, m_ovf;
    int         m_lvl;

    fifo_write_ctl #(.A_SIZE(A), .AF_THRESH(12)) dut (
        .wclk(wclk), .wrst(wrst), .wen(wen), .ovf_clr(ovf_clr), .rptr(rptr),
        .waddr(waddr), .wptr(wptr), .full(full), .almost_full(almost_full),
        .wlevel(wlevel), .overflow(overflow)
    );

    fifo_write_ctl #(.A_SIZE(A), .AF_THRESH(1)) dut_t1 (
        .wclk(wclk), .wrst(wrst), .wen(wen2), .ovf_clr(1'b0), .rptr(rptr2),
        .waddr(waddr2), .wptr(wptr2), .full(full2), .almost_full(almost_full2),
        .wlevel(wlevel2), .overflow(overflow2)
    );

    always #5 wclk = ~wclk;

    function automatic int g2b(input logic [A:0] g);
        int b = 0;
        for (int i = A; i >= 0; i--) begin
            b = b ^ (g >> i);
        end
        return b & (LAP - 1);
    endfunction

    function automatic logic [A:0] b2g(input int b);
        logic [A:0] x;
        x = b[A:0];
        return x ^ (x >> 1);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        m_wr = 0; m_s1 = '0; m_s2 = '0;
        m_full = 0; m_af = 0; m_ovf = 0; m_lvl = 0;
    endtask

    // One clock edge: advance the model from the inputs present at the edge.
    task automatic tick();
        int   rb;
        bit   accept;
        @(posedge wclk);
        if (wrst) begin
            model_reset();
        end else begin
            accept = wen && !m_full;
            rb     = g2b(m_s2);
            if (wen && m_full)  m_ovf = 1;
            else if (ovf_clr)   m_ovf = 0;
            m_wr  = m_wr + (accept ? 1 : 0);
            m_lvl = ((m_wr % LAP) - rb + LAP) % LAP;
            m_full = (m_lvl == DEPTH);
            m_af   = (m_lvl >= 12);
            m_s2 = m_s1;
            m_s1 = rptr;
        end
        #1;
    endtask

    // Per-cycle comparison of the main instance against the model.
    always @(negedge wclk) begin
        if (chk_en && !wrst) begin
            chk("waddr",       32'(waddr),       32'(m_wr % DEPTH));
            chk("wptr",        32'(wptr),        32'(b2g(m_wr % LAP)));
            chk("full",        32'(full),        32'(m_full));
            chk("almost_full", 32'(almost_full), 32'(m_af));
            chk("wlevel",      32'(wlevel),      32'(m_lvl));
            chk("overflow",    32'(overflow),    32'(m_ovf));
        end
    end

    logic [A:0] w_hist [0:63];
    logic [A:0] prev_wptr;

    initial begin
        model_reset();
        tick(); tick();
        wrst = 1'b0;
        chk_en = 1'b1;
        chk("rst_waddr", 32'(waddr), 0);
        chk("rst_full",  32'(full), 0);
        $display("reset released: waddr=%0d wptr=%b", waddr, wptr);

        // Reset in the middle of a burst, checked without any clock edge.
        wen = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            $display("burst write %0d: waddr=%0d wptr=%b", i, waddr, wptr);
        end
        #2;
        wrst = 1'b1;
        #1;
        chk("async_waddr",    32'(waddr),    0);
        chk("async_wptr",     32'(wptr),     0);
        chk("async_full",     32'(full),     0);
        chk("async_wlevel",   32'(wlevel),   0);
        chk("async_overflow", 32'(overflow), 0);
        $display("async reset: waddr=%0d wptr=%b wlevel=%0d", waddr, wptr, wlevel);
        wen = 1'b0;
        tick();
        wrst = 1'b0;

        // Fill 16 entries with the read pointer held at zero.
        wen = 1'b1;
        for (int i = 1; i <= DEPTH; i++) begin
            tick();
            $display("fill write %0d: waddr=%0d wlevel=%0d af=%0b full=%0b", i, waddr, wlevel, almost_full, full);
            if (i == 11) chk("af_before_12", 32'(almost_full), 0);
            if (i == 12) chk("af_at_12",     32'(almost_full), 1);
            if (i == 15) chk("full_at_15",   32'(full), 0);
        end
        chk("fill_full",   32'(full),   1);
        chk("fill_wlevel", 32'(wlevel), 16);
        chk("fill_waddr",  32'(waddr),  0);
        chk("fill_wptr",   32'(wptr),   32'b11000);

        // Writes while full are rejected and flag overflow.
        for (int i = 0; i < 3; i++) begin
            tick();
            $display("write while full %0d: waddr=%0d ovf=%0b", i, waddr, overflow);
        end
        wen = 1'b0;
        chk("ovf_waddr", 32'(waddr),    0);
        chk("ovf_wptr",  32'(wptr),     32'b11000);
        chk("ovf_set",   32'(overflow), 1);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        chk("ovf_clr", 32'(overflow), 0);
        $display("ovf_clr: ovf=%0b", overflow);
        wen = 1'b1; ovf_clr = 1'b1;
        tick();
        wen = 1'b0; ovf_clr = 1'b0;
        chk("ovf_set_wins", 32'(overflow), 1);
        $display("wen+ovf_clr: ovf=%0b", overflow);

        // One read becomes visible on the third edge.
        rptr = 5'b00001;
        tick(); chk("drain_full_e1", 32'(full), 1);
        tick(); chk("drain_full_e2", 32'(full), 1);
        tick();
        chk("drain_full_e3",   32'(full),        0);
        chk("drain_wlevel_e3", 32'(wlevel),      15);
        chk("drain_af_e3",     32'(almost_full), 1);
        $display("drain: full=%0b wlevel=%0d af=%0b", full, wlevel, almost_full);

        // Wrap: 40 writes with rptr trailing wptr by two edges.
        wrst = 1'b1; rptr = '0;
        tick();
        wrst = 1'b0;
        wen = 1'b1;
        prev_wptr = wptr;
        for (int i = 0; i < 40; i++) begin
            rptr = (i >= 2) ? w_hist[i-2] : '0;
            tick();
            w_hist[i] = wptr;
            chk("wrap_not_full", 32'(full), 0);
            chk("wrap_one_bit",  32'($countones(wptr ^ prev_wptr)), 1);
            prev_wptr = wptr;
            $display("wrap write %0d: waddr=%0d wptr=%b wlevel=%0d", i + 1, waddr, wptr, wlevel);
            if (i == 30) chk("wrap_wptr_31", 32'(wptr), 32'b10000);
            if (i == 31) begin
                chk("wrap_wptr_0",  32'(wptr),  0);
                chk("wrap_waddr_0", 32'(waddr), 0);
            end
        end
        wen = 1'b0;

        // Threshold of one on the second instance.
        wen2 = 1'b1;
        tick();
        wen2 = 1'b0;
        chk("t1_af_first",  32'(almost_full2), 1);
        chk("t1_level_one", 32'(wlevel2),      1);
        rptr2 = 5'b00001;
        tick(); chk("t1_af_e1", 32'(almost_full2), 1);
        tick(); chk("t1_af_e2", 32'(almost_full2), 1);
        tick();
        chk("t1_af_e3",    32'(almost_full2), 0);
        chk("t1_level_e3", 32'(wlevel2),      0);
        $display("threshold one: af=%0b wlevel=%0d", almost_full2, wlevel2);

        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fifo_write_ctl.md
# fifo_write_ctl

Write-side controller of the dual-clock FIFO, sitting directly upstream of the read-side controller. It owns the write binary/Gray pointer pair and drives the RAM write address. It synchronizes the read-domain Gray pointer into the write clock domain and produces registered full, almost-full, fill-level and sticky overflow status. Its Gray output `wptr` is the pointer the read side double-registers to compute empty.

## Interface
- `A_SIZE`, 4: RAM address width; depth = 2^A_SIZE; minimum 2.
- `AF_THRESH`, 12: almost-full threshold in entries; legal range 1..2^A_SIZE.
- `wclk`  input  1: write clock; sole clock of the block.
- `wrst`  input  1: reset, asynchronous, active-high; clears all state.
- `wen`  input  1: write request; accepted only when `full`=0.
- `ovf_clr`  input  1: synchronous clear of `overflow`.
- `rptr`  input  A_SIZE+1: read Gray pointer from the read clock domain; asynchronous to `wclk`.
- `waddr`  output  A_SIZE: RAM write address = low A_SIZE bits of the binary write pointer.
- `wptr`  output  A_SIZE+1: registered Gray write pointer, to the read side.
- `full`  output  1: registered full flag.
- `almost_full`  output  1: registered; level >= AF_THRESH.
- `wlevel`  output  A_SIZE+1: registered fill level, 0..2^A_SIZE.
- `overflow`  output  1: sticky; a write was attempted while full.

## Operation
- Accept: `winc = wen & ~full`. RAM write enable (external) = `winc`; data written at current `waddr`.
- Pointers: `bin_next = bin + winc`, modulo 2^(A_SIZE+1); `gray_next = (bin_next >> 1) ^ bin_next`. `bin` and the Gray register both load on every `wclk` edge. `wptr` is driven straight from the Gray register, so it is glitch-free and changes at most one bit per edge.
- Sync: two-flop chain `wq1 <= rptr`, `wq2 <= wq1`. Only `wq2` is used downstream of the chain.
- Read-pointer conversion: `rbin = gray2bin(wq2)`, where bit i is the XOR of `wq2[A_SIZE:i]`.
- Full: `full <= (gray_next == {~wq2[A_SIZE:A_SIZE-1], wq2[A_SIZE-2:0]})`.
- Level: `wlevel <= bin_next - rbin`, modulo 2^(A_SIZE+1). The level is pessimistic: it never under-reports the fill.
- Almost full: `almost_full <= ((bin_next - rbin) >= AF_THRESH)`.
- Overflow: set when `wen & full`; cleared when `ovf_clr`=1. If both occur on the same edge, set wins.
- A rejected write changes neither the pointers nor RAM.
- Reset values: `bin`, Gray register, `wq1`, `wq2`, `waddr`, `wptr`, `wlevel` = 0; `full`, `almost_full`, `overflow` = 0.

## Timing
- An accepted write on edge N: `waddr`, `wptr`, `full`, `wlevel` and `almost_full` all reflect it after edge N. There is no extra cycle of latency.
- The write that fills the FIFO asserts `full` on the same edge. No write beyond depth is ever accepted.
- A read-side `rptr` change reaches `wq2` after 2 `wclk` edges. `full`, `wlevel` and `almost_full` update on the 3rd edge. The status flags may stay stale-full for those cycles; this is safe.
- Wrap-around:
  - `waddr` wraps from 2^A_SIZE-1 to 0.
  - The binary pointer wraps from 2^(A_SIZE+1)-1 to 0.
  - The full comparison stays correct across both wraps.
- Reset mid-operation: all outputs go to their reset values immediately, without waiting for a clock edge. Both domains are reset together at system level.

## Test plan
- Reset: assert `wrst` mid-burst. Required: `waddr`=0, `wptr`=0, `full`=0, `wlevel`=0, `overflow`=0 with no clock edge.
- Fill (`rptr`=0 held, A_SIZE=4): 16 consecutive `wen`. Required:
  - After the 16th edge: `full`=1, `wlevel`=16, `waddr`=0, `wptr`=5'b11000.
  - `almost_full` rises after the 12th edge.
- Overflow: with `full`=1, pulse `wen` 3 times. Required:
  - Pointers unchanged, `overflow`=1.
  - `ovf_clr` pulse then drops `overflow`.
  - Simultaneous `wen`&`ovf_clr` while full keeps `overflow`=1.
- Drain visibility: from full, drive `rptr`=5'b00001 (one read). Required:
  - `full` stays 1 for 2 edges and drops on the 3rd.
  - `wlevel`=15 and `almost_full`=1 on the same edge.
- Wrap: 40 writes, with `rptr` tracking `wptr` 2 edges behind. Required:
  - `full` never asserts.
  - `wptr` changes exactly one bit per accepted write.
  - The binary pointer passes 31 to 0 correctly.
- Threshold: AF_THRESH=1. The first write asserts `almost_full` after that edge; it deasserts 3 edges after `rptr` catches up.
